// File: rtl/cdc_hs_rx.sv
// Four-phase handshake receiver: synchronises in_req into out_clk and buffers words in a 2-entry FIFO.
// Latency: in_req rise to capture <= SYNC_STAGES+1 edges; capture to out_valid 1 cycle.
// Backpressure: a full FIFO stalls the handshake (in_ack held low), so no word is ever dropped.
`timescale 1ns/1ps
module cdc_hs_rx #(
    parameter int NUM_OF_BITS = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   out_clk,
    input  logic                   rst,
    input  logic                   in_req,
    input  logic [NUM_OF_BITS-1:0] in_data,
    output logic                   in_ack,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_OF_BITS-1:0] out_data,
    output logic                   busy
);

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic                   capture;
    logic                   pop;
    logic                   can_accept;

    logic [NUM_OF_BITS-1:0] mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;

    always_ff @(posedge out_clk or posedge rst) begin
        if (rst) begin
            req_sync <= '0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], in_req};
        end
    end

    assign req_s      = req_sync[SYNC_STAGES-1];
    assign out_valid  = (count != 2'd0);
    assign pop        = out_valid && out_ready;
    // A pop on the same edge frees the slot the new word lands in.
    assign can_accept = (count != 2'd2) || pop;
    assign out_data   = mem[rd_ptr];
    assign busy       = (state == ACK);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (req_s && can_accept) begin
                    state_nxt = ACK;
                    capture   = 1'b1;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge out_clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            in_ack <= 1'b0;
        end else begin
            state  <= state_nxt;
            in_ack <= (state_nxt == ACK);
        end
    end

    always_ff @(posedge out_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (capture) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({capture, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Randomised bench for cdc_hs_rx: a queue-based model of the word stream plus directed handshake scenarios.
`timescale 1ns/1ps
module tb_cdc_hs_rx;
    localparam int W  = 32;
    localparam int SS = 2;

    logic         out_clk = 1'b0;
    logic         rst;
    logic         in_req;
    logic [W-1:0] in_data;
    logic         in_ack;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    int           nvec = 0;
    int           nerr = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] cur_word;
    bit           hold;
    bit           rnd_ready;
    int           e;

    always #5 out_clk = ~out_clk;

    cdc_hs_rx #(.NUM_OF_BITS(W), .SYNC_STAGES(SS)) dut (
        .out_clk  (out_clk),
        .rst      (rst),
        .in_req   (in_req),
        .in_data  (in_data),
        .in_ack   (in_ack),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Every accepted pop must deliver the oldest word the transmitter saw acknowledged.
    always @(negedge out_clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) check("spurious_pop", W'(q.size()), 1);
            else               check("out_data", out_data, q.pop_front());
        end
    end

    always @(posedge in_ack) check("ack_while_req_low", W'(in_req), 1);

    // Outside the hold window in_data is garbage that must never reach out_data.
    always @(posedge out_clk) begin
        #4;
        if (!hold) in_data = $urandom;
    end

    always @(posedge out_clk) begin
        #1;
        if (rnd_ready) out_ready = $urandom_range(0, 1) == 1;
    end

    task automatic raise(input logic [W-1:0] w);
        @(posedge out_clk);
        #($urandom_range(0, 3) * 2 + 1);
        hold     = 1'b1;
        in_data  = w;
        cur_word = w;
        in_req   = 1'b1;
    endtask

    task automatic wait_ack(input string tag, output int edges);
        edges = 0;
        while (!in_ack && edges < 400) begin
            @(posedge out_clk);
            #1;
            edges++;
        end
        check(tag, W'(in_ack), 1);
        if (in_ack) q.push_back(cur_word);
        hold = 1'b0;
    endtask

    task automatic drop(input string tag, output int edges);
        @(posedge out_clk);
        #($urandom_range(0, 3) * 2 + 1);
        in_req = 1'b0;
        edges  = 0;
        while (in_ack && edges < 50) begin
            @(posedge out_clk);
            #1;
            edges++;
        end
        check(tag, W'(in_ack), 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge out_clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; in_req = 1'b0; out_ready = 1'b0; in_data = '0;
        hold = 1'b0; rnd_ready = 1'b0; cur_word = '0;
        idle_cycles(3);
        check("rst_ack",   W'(in_ack),    0);
        check("rst_valid", W'(out_valid), 0);
        check("rst_data",  out_data,      0);
        check("rst_busy",  W'(busy),      0);
        @(negedge out_clk);
        rst = 1'b0;

        // Single transfer with a ready sink
        out_ready = 1'b1;
        raise(32'hA5A5_0001);
        wait_ack("t1_ack", e);
        check("t1_lat",   W'(e <= SS + 1), 1);
        check("t1_valid", W'(out_valid), 1);
        check("t1_data",  out_data, 32'hA5A5_0001);
        check("t1_busy",  W'(busy), 1);
        idle_cycles(1);
        check("t1_valid_one_cycle", W'(out_valid), 0);
        drop("t1_rel", e);
        check("t1_rel_lat", W'(e <= SS + 1), 1);
        check("t1_idle", W'(busy), 0);

        // Backpressure: two words buffer, third stalls
        idle_cycles(1);
        out_ready = 1'b0;
        raise(32'h1); wait_ack("bp1_ack", e); drop("bp1_rel", e);
        raise(32'h2); wait_ack("bp2_ack", e); drop("bp2_rel", e);
        check("bp_count", W'(dut.count), 2);
        raise(32'h3);
        idle_cycles(8);
        check("bp_stall_ack",  W'(in_ack), 0);
        check("bp_stall_busy", W'(busy), 0);
        check("bp_head",       out_data, 32'h1);
        out_ready = 1'b1;
        wait_ack("bp3_ack", e);
        drop("bp3_rel", e);
        idle_cycles(4);
        check("bp_drained", W'(q.size()), 0);

        // Full buffer with pop and capture on the same edge
        out_ready = 1'b0;
        raise(32'h10); wait_ack("full1_ack", e); drop("full1_rel", e);
        raise(32'h11); wait_ack("full2_ack", e); drop("full2_rel", e);
        raise(32'h12);
        idle_cycles(6);
        check("full_stall", W'(in_ack), 0);
        out_ready = 1'b1;
        idle_cycles(1);
        out_ready = 1'b0;
        check("full_pop_ack", W'(in_ack), 1);
        check("full_count",   W'(dut.count), 2);
        check("full_head",    out_data, 32'h11);
        q.push_back(32'h12);
        hold = 1'b0;
        drop("full_rel", e);
        out_ready = 1'b1;
        idle_cycles(4);
        check("full_drained", W'(q.size()), 0);

        // Reset in the middle of a handshake with one word buffered
        out_ready = 1'b0;
        raise(32'h55);
        wait_ack("mid_ack", e);
        @(negedge out_clk);
        #2;
        rst = 1'b1; hold = 1'b1; in_data = 32'h66; cur_word = 32'h66;
        #1;
        check("mid_rst_ack",   W'(in_ack),    0);
        check("mid_rst_valid", W'(out_valid), 0);
        check("mid_rst_busy",  W'(busy),      0);
        q.delete();
        @(negedge out_clk);
        #2;
        rst = 1'b0;
        wait_ack("mid_recap", e);
        check("mid_recap_lat", W'(e <= SS + 1), 1);
        out_ready = 1'b1;
        drop("mid_rel", e);
        idle_cycles(4);
        check("mid_drained", W'(q.size()), 0);

        // Random stream with random sink readiness
        rnd_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            raise($urandom);
            wait_ack("rnd_ack", e);
            drop("rnd_rel", e);
            repeat ($urandom_range(0, 3)) @(posedge out_clk);
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        idle_cycles(10);
        check("final_drain", W'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/cdc_hs_rx.md
CDC_HS_RX -- requirements
Module: cdc_hs_rx

Interface
REQ-001 The block SHALL have parameter NUM_OF_BITS, default 32: data word width, legal range 1-72.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: number of req synchronizer flops, legal range 2-4.
REQ-003 The block SHALL have port out_clk, input, 1 bit: the single clock; all state is in this domain.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-high.
REQ-005 The block SHALL have port in_req, input, 1 bit: four-phase request from the transmitting domain; asynchronous to out_clk.
REQ-006 The block SHALL have port in_data, input, NUM_OF_BITS bits: payload; held stable by the transmitter from in_req rise until in_ack rise.
REQ-007 The block SHALL have port in_ack, output, 1 bit: four-phase acknowledge, driven directly from a flop.
REQ-008 The block SHALL have port out_valid, output, 1 bit: output buffer non-empty.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-010 The block SHALL have port out_data, output, NUM_OF_BITS bits: head-of-buffer word.
REQ-011 The block SHALL have port busy, output, 1 bit: high when the FSM is not IDLE.

Function
REQ-012 in_req SHALL pass through SYNC_STAGES flops; only the last stage (req_s) SHALL be used by logic.
REQ-013 The FSM SHALL have exactly two states: IDLE and ACK.
REQ-014 IDLE -> ACK when req_s=1 and the buffer can accept (count<2, or count=2 with a pop in the same cycle); on that edge in_data is written to the buffer tail and in_ack<=1.
REQ-015 IDLE with req_s=1 and buffer unable to accept: remain IDLE, in_ack=0, no capture (stall, no data loss).
REQ-016 ACK -> IDLE when req_s=0; on that edge in_ack<=0; ACK with req_s=1: hold.
REQ-017 busy SHALL equal (state==ACK).
REQ-018 The output buffer SHALL be a 2-entry FIFO: count 0..2, wrap-around read/write pointers.
REQ-019 A pop occurs when out_valid=1 and out_ready=1; out_data advances to the next entry on that edge.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-021 out_valid SHALL equal (count!=0); out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 Latency: in_req rising edge to capture SHALL be SYNC_STAGES+1 out_clk edges maximum; capture edge to out_valid=1 SHALL be 1 cycle (when the buffer was empty).
REQ-023 in_data SHALL be sampled only on the capture edge; no other cycle's in_data SHALL reach out_data.
REQ-024 A pop with count=0 SHALL be ignored; count SHALL never exceed 2 or underflow.

Reset
REQ-025 While rst=1: state=IDLE, all sync flops=0, in_ack=0, count=0, pointers=0, out_valid=0, out_data=0, busy=0.
REQ-026 rst asserted mid-handshake SHALL drop in_ack immediately (asynchronously) and discard buffered words; after release, the FSM SHALL restart from IDLE and re-capture if in_req is still high.

Verification
REQ-027 Single transfer, SYNC_STAGES=2, out_ready=1: in_data=0xA5A5_0001 with in_req 0->1 -> capture within 3 edges, in_ack=1, out_valid=1 for one cycle with out_data=0xA5A5_0001; in_req=0 -> in_ack=0 within 3 edges.
REQ-028 Backpressure: out_ready=0, three transfers 0x1, 0x2, 0x3 -> first two acked and buffered (count=2), third stalls with in_ack=0; raise out_ready -> outputs 0x1, 0x2, 0x3 in order, none lost or duplicated.
REQ-029 Full with simultaneous pop: count=2, req_s=1 and out_ready=1 in the same cycle -> capture occurs, count stays 2, order preserved.
REQ-030 Data stability: toggle in_data every cycle except the capture window -> out_data equals only the value present on the capture edge.
REQ-031 Reset mid-op: assert rst while state=ACK with count=1 -> in_ack=0 and out_valid=0 with no clock edge; release with in_req=1 -> new capture and in_ack=1 within SYNC_STAGES+1 edges.
REQ-032 Random async stream: 1000 transfers at a random in_req phase and random out_ready -> output sequence equals input sequence, and in_ack never rises while in_req=0.
